// File: rtl/mux_4b.sv
// mux_4b: registered 2:1 address-source select (program counter vs RAM side).
// Each output bit is a lane instance; outSel records the select last loaded.
// Optional build macro MUX_CLR_EN: a non-enabled edge clears the outputs
// (gated OR-bus driver) instead of holding them.

module mux_4b_lane (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic sel,
    input  logic pbit,
    input  logic rbit,
    output logic obit
);
    // one output bit: reset > load selected source > hold/clear
    always_ff @(posedge clk) begin
        if (rst)
            obit <= 1'b0;
        else if (enable)
            obit <= sel ? rbit : pbit;
`ifdef MUX_CLR_EN
        else
            obit <= 1'b0;
`else
        else
            obit <= obit;
`endif
    end
endmodule

module mux_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sel,
    input  logic [WIDTH-1:0] programP,
    input  logic [WIDTH-1:0] Ram,
    output logic [WIDTH-1:0] outBits,
    output logic             outSel
);
    // bitwise lanes for the data path
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        mux_4b_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .enable (enable),
            .sel    (sel),
            .pbit   (programP[i]),
            .rbit   (Ram[i]),
            .obit   (outBits[i])
        );
    end

    // select tag follows the same reset/load/idle rules as the data
    always_ff @(posedge clk) begin
        if (rst)
            outSel <= 1'b0;
        else if (enable)
            outSel <= sel;
`ifdef MUX_CLR_EN
        else
            outSel <= 1'b0;
`else
        else
            outSel <= outSel;
`endif
    end
endmodule

// File: tb/tb_mux_4b.sv
module tb_mux_4b;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, enable, sel;
    logic [W-1:0] programP, Ram;
    logic [W-1:0] outBits;
    logic         outSel;

    typedef struct packed {
        logic [W-1:0] bits;
        logic         s;
    } exp_t;

    exp_t exp_q[$];
    exp_t model;
    int   vectors = 0;
    int   miscompares = 0;

    mux_4b #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .sel      (sel),
        .programP (programP),
        .Ram      (Ram),
        .outBits  (outBits),
        .outSel   (outSel)
    );

    always #5 clk = ~clk;

    // reference: what the output pair should hold after the coming edge
    function automatic exp_t predict(exp_t cur, logic r, logic e, logic s,
                                     logic [W-1:0] p, logic [W-1:0] m);
        exp_t n;
        if (r) begin
            n.bits = '0; n.s = 1'b0;
        end else if (e) begin
            n.bits = (s == 1'b1) ? m : p;
            n.s = s;
        end else begin
`ifdef MUX_CLR_EN
            n.bits = '0; n.s = 1'b0;
`else
            n = cur;
`endif
        end
        return n;
    endfunction

    // drive one edge's inputs, optionally glitch them mid-cycle, queue expectation
    task automatic step(input logic r, input logic e, input logic s,
                        input logic [W-1:0] p, input logic [W-1:0] m,
                        input bit glitch);
        rst = r; enable = e; sel = s; programP = p; Ram = m;
        if (glitch) begin
            #1 sel = ~s; Ram = ~m;
            #1 sel = s;  Ram = m;
        end
        model = predict(model, r, e, s, p, m);
        @(posedge clk);
        exp_q.push_back(model);
        #1;
    endtask

    // monitor: outputs are presented every cycle; compare mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            vectors++;
            if (outBits !== x.bits || outSel !== x.s) begin
                miscompares++;
                $display("FAIL vec%0d: got outBits=%0d outSel=%0b, want outBits=%0d outSel=%0b",
                         vectors, outBits, outSel, x.bits, x.s);
            end
        end
    end

    initial begin
        model = '0;
        step(1'b1, 1'b1, 1'b1, 4'd0,  4'd9,  1'b0); // reset beats enable
        step(1'b0, 1'b1, 1'b0, 4'd15, 4'd15, 1'b0); // pc select, equal inputs
        step(1'b0, 1'b1, 1'b1, 4'd15, 4'd7,  1'b0); // ram select
        step(1'b0, 1'b0, 1'b0, 4'd3,  4'd0,  1'b0); // disabled edge
        step(1'b0, 1'b1, 1'b1, 4'd2,  4'd5,  1'b1); // mid-cycle glitch
        step(1'b0, 1'b1, 1'b0, 4'd6,  4'd6,  1'b0); // equal inputs, sel 0
        step(1'b0, 1'b1, 1'b1, 4'd6,  4'd6,  1'b0); // equal inputs, sel 1
        step(1'b1, 1'b1, 1'b0, 4'd12, 4'd0,  1'b0); // reset priority
        step(1'b0, 1'b1, 1'b0, 4'd12, 4'd0,  1'b0); // loads after reset
        step(1'b0, 1'b0, 1'b1, 4'd1,  4'd1,  1'b0); // idle again
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(15) == 0), ($urandom_range(3) != 0),
                 1'($urandom), W'($urandom), W'($urandom), ($urandom_range(7) == 0));
        end
        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
